// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 4-digit seven-segment scanner:
// segment pattern table, blank/none constants, slot encodings and the
// shadow-register bundle.
package seg_pkg;

  // Active-low segment pattern when every segment is dark.
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  // Active-low digit enables with no digit selected.
  localparam logic [3:0] DIG_NONE = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  // The packed array is indexed by the nibble value, so entry 0 sits
  // at the rightmost position of the concatenation.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Slot index: also the bit position of the active digit enable.
  typedef enum logic [1:0] {
    SLOT_ANS_L = 2'd0,
    SLOT_ANS_H = 2'd1,
    SLOT_NUM2  = 2'd2,
    SLOT_NUM1  = 2'd3
  } slot_e;

  // Captured operand/result nibbles shown on the display.
  typedef struct packed {
    logic [3:0] num1;
    logic [3:0] num2;
    logic [3:0] ans_h;
    logic [3:0] ans_l;
  } shadow_t;

  // Active-low one-hot digit enable for a slot.
  function automatic logic [3:0] dig_sel(slot_e s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/seg_dec.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Straight table lookup; every nibble value has an entry.
  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner with registered outputs.
// Each digit slot lasts SCAN_DIV cycles; the first BLANK_CYC cycles of a
// slot are dark to stop ghosting between digits.
// Optional build macro SEG_SCAN_LZ_BLANK_EN: when defined, a zero high
// result nibble is shown dark instead of as '0' (digit enable stays on).
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] num1_seg,
  input  logic [3:0] num2_seg,
  input  logic [3:0] ans_h,
  input  logic [3:0] ans_l,
  output logic [3:0] dig_n,
  output logic [6:0] seg,
  output logic       frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt;
  slot_e            idx;
  shadow_t          shadow;
  logic [3:0]       nib;
  logic [6:0]       dec_seg;
  logic [6:0]       slot_seg;
  logic             slot_end;
  logic             blank;

  assign slot_end = (cnt == CNT_W'(SCAN_DIV - 1));
  // Signed compare keeps BLANK_CYC=0 well-defined (never blank).
  assign blank    = (int'(cnt) < BLANK_CYC);

  // Pick the shadow nibble belonging to the current slot.
  // NOTE: a default assignment first means no path leaves nib unassigned, so no latch is inferred.
  always_comb begin
    nib = shadow.ans_l;
    unique case (idx)
      SLOT_ANS_L: nib = shadow.ans_l;
      SLOT_ANS_H: nib = shadow.ans_h;
      SLOT_NUM2:  nib = shadow.num2;
      SLOT_NUM1:  nib = shadow.num1;
    endcase
  end

  seg_dec u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  // Optional leading-zero suppression on the high result digit.
  always_comb begin
`ifdef SEG_SCAN_LZ_BLANK_EN
    slot_seg = dec_seg;
    if (idx == SLOT_ANS_H && shadow.ans_h == 4'h0) slot_seg = SEG_OFF;
`else
    slot_seg = dec_seg;
`endif
  end

  // Prescaler, slot index and shadow capture; reset discards the partial slot.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= SLOT_ANS_L;
      shadow <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CNT_W'(1);
      if (slot_end) idx <= slot_e'(idx + 2'd1);
      if (load) shadow <= '{num1: num1_seg, num2: num2_seg, ans_h: ans_h, ans_l: ans_l};
    end
  end

  // Registered display outputs and end-of-frame pulse from the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig_n      <= DIG_NONE;
      seg        <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      dig_n      <= blank ? DIG_NONE : dig_sel(idx);
      seg        <= blank ? SEG_OFF  : slot_seg;
      frame_tick <= slot_end && (idx == SLOT_NUM1);
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan with SCAN_DIV=4, BLANK_CYC=1.
// A cycle-count reference model predicts every output cycle; directed
// steps add literal expectations for the documented scenarios.
module tb_seg_scan;

  localparam int D = 4;
  localparam int B = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] num1_seg = 4'h0;
  logic [3:0] num2_seg = 4'h0;
  logic [3:0] ans_h = 4'h0;
  logic [3:0] ans_l = 4'h0;
  logic [3:0] dig_n;
  logic [6:0] seg;
  logic       frame_tick;

  seg_scan #(.SCAN_DIV(D), .BLANK_CYC(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .num1_seg   (num1_seg),
    .num2_seg   (num2_seg),
    .ans_h      (ans_h),
    .ans_l      (ans_l),
    .dig_n      (dig_n),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: edges since reset release plus the four displayed
  // nibbles indexed by digit position (0 ans_l, 1 ans_h, 2 num2, 3 num1).
  int         n = 0;
  logic [3:0] sh [4];
  logic [6:0] pat [16];
  logic [3:0] exp_dig;
  logic [6:0] exp_seg;
  logic       exp_tick;

  function automatic logic [6:0] shown(int s, logic [3:0] v);
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (s == 1 && v == 4'h0) return 7'h7F;
`endif
    return pat[v];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: predict from pre-edge model state and inputs, clock, compare.
  task automatic tick();
    int p;
    int s;
    if (!rst_n) begin
      exp_dig  = 4'hF;
      exp_seg  = 7'h7F;
      exp_tick = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) sh[i] = 4'h0;
    end else begin
      p = n % D;
      s = (n / D) % 4;
      exp_dig  = (p < B) ? 4'hF : ~(4'(1) << s);
      exp_seg  = (p < B) ? 7'h7F : shown(s, sh[s]);
      exp_tick = ((n % (4 * D)) == (4 * D - 1));
      n++;
      if (load) begin
        sh[0] = ans_l;
        sh[1] = ans_h;
        sh[2] = num2_seg;
        sh[3] = num1_seg;
      end
    end
    @(posedge clk);
    #1;
    check("model_dig_n", 32'(dig_n), 32'(exp_dig));
    check("model_seg", 32'(seg), 32'(exp_seg));
    check("model_frame_tick", 32'(frame_tick), 32'(exp_tick));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_nibs(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] h, input logic [3:0] l);
    num1_seg = a;
    num2_seg = b;
    ans_h    = h;
    ans_l    = l;
  endtask

  initial begin
    logic [3:0] obs_dig [16];
    logic [6:0] obs_seg [16];
    logic [3:0] want_dig [4];
    logic [6:0] want_seg [4];
    int tick_cnt;
    int tick_at [$];

    pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int i = 0; i < 4; i++) sh[i] = 4'h0;

    // Reset for one cycle: blank outputs, no frame pulse.
    @(negedge clk);
    do_reset();
    check("reset_dig_n", 32'(dig_n), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_tick", 32'(frame_tick), 32'h0);

    // Load 3/5/1/8 on the first edge, then observe one full frame.
    set_nibs(4'h3, 4'h5, 4'h1, 4'h8);
    load = 1'b1;
    tick();
    obs_dig[0] = dig_n;
    obs_seg[0] = seg;
    load = 1'b0;
    for (int k = 1; k < 16; k++) begin
      tick();
      obs_dig[k] = dig_n;
      obs_seg[k] = seg;
    end
    want_dig = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    want_seg = '{7'h00, 7'h79, 7'h12, 7'h30};
    for (int s = 0; s < 4; s++) begin
      check($sformatf("frame_blank_dig_%0d", s), 32'(obs_dig[4*s]), 32'hF);
      check($sformatf("frame_blank_seg_%0d", s), 32'(obs_seg[4*s]), 32'h7F);
      check($sformatf("frame_dig_%0d", s), 32'(obs_dig[4*s+1]), 32'(want_dig[s]));
      check($sformatf("frame_seg_%0d", s), 32'(obs_seg[4*s+1]), 32'(want_seg[s]));
    end

    // Free run 64 cycles: four frame pulses, 16 cycles apart.
    tick_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (frame_tick === 1'b1) begin
        tick_cnt++;
        tick_at.push_back(k);
      end
    end
    check("free_run_tick_count", 32'(tick_cnt), 32'd4);
    for (int i = 1; i < tick_at.size(); i++)
      check($sformatf("free_run_tick_gap_%0d", i), 32'(tick_at[i] - tick_at[i-1]), 32'd16);

    // Zero high result nibble on slot 1.
    do_reset();
    set_nibs(4'h2, 4'h4, 4'h0, 4'h6);
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    check("lz_dig_n", 32'(dig_n), 32'b1101);
`ifdef SEG_SCAN_LZ_BLANK_EN
    check("lz_seg", 32'(seg), 32'h7F);
`else
    check("lz_seg", 32'(seg), 32'h40);
`endif

    // Mid-slot load during slot 0: new digit appears without slot restart.
    do_reset();
    set_nibs(4'h0, 4'h0, 4'h0, 4'h8);
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("midload_before", 32'(seg), 32'h00);
    ans_l = 4'h1;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("midload_capture_edge", 32'(seg), 32'h00);
    tick();
    check("midload_after", 32'(seg), 32'h79);
    check("midload_dig_same_slot", 32'(dig_n), 32'b1110);
    tick();
    check("midload_slot_end_blank", 32'(dig_n), 32'hF);
    tick();
    check("midload_next_slot", 32'(dig_n), 32'b1101);

    // Reset mid-scan at cnt=2, idx=2, then restart at slot 0 with zeros.
    do_reset();
    set_nibs(4'h9, 4'h7, 4'hA, 4'hC);
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    check("midscan_pre_dig", 32'(dig_n), 32'b1011);
    rst_n = 1'b0;
    load = 1'b1;
    tick();
    check("midscan_rst_dig", 32'(dig_n), 32'hF);
    check("midscan_rst_seg", 32'(seg), 32'h7F);
    check("midscan_rst_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    load = 1'b0;
    tick();
    check("restart_blank", 32'(dig_n), 32'hF);
    tick();
    check("restart_dig", 32'(dig_n), 32'b1110);
    check("restart_seg", 32'(seg), 32'h40);

    // Randomized loads, nibbles and occasional resets against the model.
    for (int k = 0; k < 400; k++) begin
      set_nibs(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      load  = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      tick();
    end
    rst_n = 1'b1;
    load = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_nibs(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot; legal range 2 or more.
REQ-002 SHALL have parameter BLANK_CYC, default 500, anti-ghost blank cycles at the start of each slot; legal range 0 to SCAN_DIV-1.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port load, input, 1, capture strobe for the four operand/result nibbles.
REQ-006 SHALL have ports num1_seg and num2_seg, input, 4 each, calculator operands to display.
REQ-007 SHALL have ports ans_h and ans_l, input, 4 each, calculator result high and low nibble.
REQ-008 SHALL have port dig_n, output, 4, active-low digit enables: bit0 ans_l, bit1 ans_h, bit2 num2, bit3 num1.
REQ-009 SHALL have port seg, output, 7, active-low segments ordered {g,f,e,d,c,b,a}.
REQ-010 SHALL have port frame_tick, output, 1, one-cycle pulse per completed 4-digit frame.

Function
REQ-011 SHALL hold 4 shadow nibbles; load=1 at a clock edge captures all four inputs, otherwise they hold.
REQ-012 SHALL keep prescaler cnt counting 0 to SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and slot index idx advances 0->1->2->3->0.
REQ-013 SHALL register all outputs: values in cycle t+1 reflect cnt, idx and shadow registers in cycle t.
REQ-014 SHALL drive dig_n=4'b1111 and seg=7'h7F while cnt < BLANK_CYC (blank window).
REQ-015 SHALL otherwise drive dig_n low on bit idx only and seg with the hex pattern of the shadow nibble selected by idx.
REQ-016 SHALL decode nibbles 0-F to patterns 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, active-low).
REQ-017 SHALL pulse frame_tick for exactly one cycle, registered, when idx wraps 3->0.
REQ-018 SHALL show a mid-slot load on the next output cycle, with no restart of the slot or prescaler.
REQ-019 SHALL treat load asserted in every cycle as continuous capture.

Reset
REQ-020 SHALL, on a clock edge with rst_n=0, force cnt=0, idx=0, shadows=0, dig_n=4'b1111, seg=7'h7F, frame_tick=0.
REQ-021 SHALL ignore load during reset and apply a reset mid-scan on the next edge, discarding the partial slot.
REQ-022 SHALL start the first slot after reset release at cnt=0, idx=0, blank window first.

Configuration
REQ-023 SHALL honour macro SEG_SCAN_LZ_BLANK_EN: when defined and shadow ans_h==0, slot 1 drives seg=7'h7F with dig_n bit1 still low; when undefined, slot 1 shows 7'h40.

Structure
REQ-024 SHALL place the 16-entry segment pattern table, SEG_OFF (7'h7F), DIG_NONE (4'b1111) and the slot index encodings in a shared package seg_pkg.
REQ-025 SHALL implement the nibble-to-segment decode as sub-module seg_dec, combinational, 4 in, 7 out; seg_scan registers its output.

Verification
All scenarios use SCAN_DIV=4, BLANK_CYC=1.
REQ-026 SHALL cover: rst_n low 1 cycle -> dig_n=1111, seg=7F, frame_tick=0 next cycle; first enabled output is slot 0.
REQ-027 SHALL cover: load num1=3, num2=5, ans_h=1, ans_l=8 -> frame sequence {1110,00}, {1101,79}, {1011,12}, {0111,30}, each slot preceded by 1 cycle of {1111,7F}.
REQ-028 SHALL cover: free run 64 cycles -> frame_tick high exactly 4 times, 16 cycles apart.
REQ-029 SHALL cover: ans_h=0 -> slot 1 gives {1101,7F} with macro defined and {1101,40} without.
REQ-030 SHALL cover: during slot 0, ans_l 8->1 with load=1 -> seg 00->79 one cycle later, slot length unchanged.
REQ-031 SHALL cover: rst_n low at cnt=2, idx=2 -> outputs blank next cycle; after release, slot 0 restarts and shadows read 0 (seg 40).
